// File: rtl/mean_filt_sched.sv
// Time-shares one 5-tap sliding-window mean engine among NCH streams with round-robin grants.
// Request to out_valid is 4 cycles, one sample per 5 cycles overall; OUT holds until out_ready, accepting nothing while stalled.
module mean_filt_sched #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          in_valid,
    input  logic [NCH*W-1:0]        in_data,
    output logic [NCH-1:0]          in_ready,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH-1:0]          ch_clr,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic [$clog2(NCH)-1:0]  out_chan,
    output logic                    out_warm,
    input  logic                    out_ready
);
    localparam int CW = $clog2(NCH);
    localparam int SW = W + 3;

    typedef enum logic [2:0] {IDLE, ACCEPT, UPDATE, DIVIDE, OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   g_q, g_d;
    logic [CW-1:0]   last_q, last_d;
    logic [W-1:0]    sample_q, sample_d;
    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [CW-1:0]   out_chan_q, out_chan_d;
    logic            out_warm_q, out_warm_d;

    logic [W-1:0]    hist_q [NCH][5];
    logic [W-1:0]    hist_d [NCH][5];
    logic [SW-1:0]   sum_q  [NCH];
    logic [SW-1:0]   sum_d  [NCH];
    logic [2:0]      cnt_q  [NCH];
    logic [2:0]      cnt_d  [NCH];

    logic [NCH-1:0]  req;
    logic [CW-1:0]   cand;
    logic [CW-1:0]   grant;
    logic            found;

    assign req = in_valid & ch_en;

    // Rotating search starting just after the last granted channel.
    always_comb begin
        found = 1'b0;
        grant = last_q;
        cand  = last_q;
        for (int k = 0; k < NCH; k++) begin
            cand = (cand == CW'(NCH - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        sample_d    = sample_q;
        in_ready_d  = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_warm_d  = out_warm_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d               = grant;
                    last_d            = grant;
                    in_ready_d[grant] = 1'b1;
                    state_d           = ACCEPT;
                end
            end
            ACCEPT: begin
                for (int i = 0; i < NCH; i++) begin
                    if (g_q == CW'(i)) sample_d = in_data[i*W +: W];
                end
                state_d = UPDATE;
            end
            UPDATE: state_d = DIVIDE;
            DIVIDE: begin
                out_data_d  = W'(sum_q[g_q] / SW'(5));
                out_warm_d  = (cnt_q[g_q] < 3'd5);
                out_chan_d  = g_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clears only land in IDLE, so an in-flight channel finishes before its history is wiped.
    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        pend_d = pend_q | ch_clr;
        if (state_q == IDLE) begin
            for (int i = 0; i < NCH; i++) begin
                if (pend_q[i] || ch_clr[i]) begin
                    for (int j = 0; j < 5; j++) hist_d[i][j] = '0;
                    sum_d[i] = '0;
                    cnt_d[i] = '0;
                end
            end
            pend_d = '0;
        end
        if (state_q == UPDATE) begin
            sum_d[g_q] = sum_q[g_q] + SW'(sample_q) - SW'(hist_q[g_q][4]);
            for (int j = 4; j > 0; j--) hist_d[g_q][j] = hist_q[g_q][j-1];
            hist_d[g_q][0] = sample_q;
            cnt_d[g_q] = (cnt_q[g_q] == 3'd5) ? 3'd5 : cnt_q[g_q] + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            last_q      <= CW'(NCH - 1);
            sample_q    <= '0;
            pend_q      <= '0;
            in_ready_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_warm_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                for (int j = 0; j < 5; j++) hist_q[i][j] <= '0;
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            sample_q    <= sample_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_warm_q  <= out_warm_d;
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_warm  = out_warm_q;

endmodule

// File: tb/tb_mean_filt_sched.sv
// Scoreboard bench for mean_filt_sched: directed samples push hand-computed means, a negedge monitor pops and compares.
module tb_mean_filt_sched;
    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int CW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     in_valid;
    logic [NCH*W-1:0]   in_data;
    logic [NCH-1:0]     in_ready;
    logic [NCH-1:0]     ch_en;
    logic [NCH-1:0]     ch_clr;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic [CW-1:0]      out_chan;
    logic               out_warm;
    logic               out_ready;

    mean_filt_sched #(.NCH(NCH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ch_en(ch_en), .ch_clr(ch_clr),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_warm(out_warm), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
        logic          w;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   spacing_on = 1'b0;
    int   last_out = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got chan %0d data %0d, required no output", out_chan, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_chan", int'(out_chan), int'(mon_e.ch));
                chk("out_data", int'(out_data), int'(mon_e.d));
                chk("out_warm", int'(out_warm), int'(mon_e.w));
                if (spacing_on) begin
                    if (last_out >= 0) chk("out_spacing", cyc - last_out, 5);
                    last_out = cyc;
                end
            end
        end
        if (in_ready != '0) begin
            chk("in_ready_onehot", int'($onehot(in_ready)), 1);
            chk("in_valid_held", int'(|(in_ready & ~in_valid)), 0);
        end
    end

    task automatic wait_ready(input logic [NCH-1:0] mask, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if ((in_ready & mask) != '0) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: got in_ready %b, required a grant on mask %b", in_ready, mask);
    endtask

    task automatic send(input int ch, input logic [W-1:0] d, input logic [W-1:0] m, input logic wm);
        exp_t e;
        logic [NCH-1:0] mask;
        bit ok;
        e.ch = ch[CW-1:0];
        e.d  = m;
        e.w  = wm;
        exp_q.push_back(e);
        mask = '0;
        mask[ch] = 1'b1;
        in_data[ch*W +: W] = d;
        in_valid[ch] = 1'b1;
        wait_ready(mask, ok);
        @(posedge clk); #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && !out_valid) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        exp_t e;
        bit ok;
        int last_acc;
        logic [W-1:0] od;
        logic [CW-1:0] oc;
        logic ow;
        logic [NCH-1:0] g_exp;

        rst_n = 1'b0; in_valid = '0; in_data = '0; ch_en = '1; ch_clr = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_chan", int'(out_chan), 0);
        chk("rst_out_warm", int'(out_warm), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All four channels requesting: two round-robin rounds.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                e.ch = c[CW-1:0];
                e.d  = (r == 0) ? W'(10 * (c + 1)) : W'(20 * (c + 1));
                e.w  = 1'b1;
                exp_q.push_back(e);
            end
        end
        in_data = {8'd200, 8'd150, 8'd100, 8'd50};
        in_valid = '1;
        spacing_on = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 8; k++) begin
            wait_ready('1, ok);
            g_exp = '0;
            g_exp[k % 4] = 1'b1;
            chk("rr_grant", int'(in_ready), int'(g_exp));
            if (k > 0) chk("grant_spacing", cyc - last_acc, 5);
            last_acc = cyc;
            @(posedge clk); #1;
            chk("in_ready_pulse", int'(in_ready), 0);
            if (k == 7) in_valid = '0;
        end
        drain();
        spacing_on = 1'b0;

        ch_clr = '1;
        @(posedge clk); #1;
        ch_clr = '0;

        // Warm-up on channel 0.
        send(0, 8'd10, 8'd2, 1'b1);
        send(0, 8'd20, 8'd6, 1'b1);
        send(0, 8'd30, 8'd12, 1'b1);
        send(0, 8'd40, 8'd20, 1'b1);
        send(0, 8'd50, 8'd30, 1'b0);
        send(0, 8'd60, 8'd40, 1'b0);
        drain();

        // Full scale on channel 2.
        for (int i = 1; i <= 5; i++) send(2, 8'd255, W'(51 * i), (i < 5));
        send(2, 8'd0, 8'd204, 1'b0);
        drain();

        // Backpressure with a competing request on channel 0.
        out_ready = 1'b0;
        send(3, 8'd25, 8'd5, 1'b1);
        in_data[0 +: W] = 8'd0;
        in_valid[0] = 1'b1;
        e.ch = 2'd0; e.d = 8'd36; e.w = 1'b0;
        exp_q.push_back(e);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("stall_out_valid", int'(out_valid), 1);
        od = out_data; oc = out_chan; ow = out_warm;
        for (int n = 0; n < 7; n++) begin
            @(posedge clk); #1;
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), int'(od));
            chk("stall_chan", int'(out_chan), int'(oc));
            chk("stall_warm", int'(out_warm), int'(ow));
            chk("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("release_grant", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        drain();

        // Clear channel 1 while its sixth sample is in UPDATE.
        for (int i = 1; i <= 5; i++) send(1, 8'd100, W'(20 * i), (i < 5));
        send(1, 8'd100, 8'd100, 1'b0);
        ch_clr[1] = 1'b1;
        @(posedge clk); #1;
        ch_clr = '0;
        send(1, 8'd50, 8'd10, 1'b1);
        drain();

        // Async reset while a channel 0 sample sits in DIVIDE.
        in_data[0 +: W] = 8'd77;
        in_valid[0] = 1'b1;
        wait_ready(4'b0001, ok);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_chan", int'(out_chan), 0);
        chk("arst_out_warm", int'(out_warm), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("post_rst_no_out", int'(out_valid), 0);
        end
        send(0, 8'd5, 8'd1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
